// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared types and constants for the UART receive path.
// Receiver FSM state encoding and the default bit time for 25 MHz / 115200 baud.
package uart_rx_fifo_pkg;

   localparam int CLKS_PER_BIT_115200 = 217;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count.
// Push while full is only accepted when a pop happens in the same cycle;
// the caller decides what a refused push means (e.g. overrun).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2)
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, empty masks rd_data
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (start + DATA_BITS [+ parity] + 1 stop, LSB first)
// feeding a FWFT receive FIFO, with sticky frame / overrun / parity flags.
// Optional parity check is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            serial_rxd,
   input  logic                            rd_en,
   output logic [DATA_BITS-1:0]            rd_data,
   output logic                            empty,
   output logic                            full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
   output logic                            frame_err,
   output logic                            overrun_err,
   output logic                            parity_err,
   input  logic                            err_clr
);

   localparam int TW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = $clog2(DATA_BITS+1);
   localparam int HALF = CLKS_PER_BIT / 2;

   // Reject unsupported configurations at elaboration
   if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx_fifo: unsupported parameter set");
   end

   rx_state_e            state_q, state_d;
   logic                 sync1_q, sync2_q, rxd_prev_q;
   logic                 rxd_s;
   logic [TW-1:0]        timer_q, timer_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_err_q, overrun_err_d;
   logic                 tick, timer_run, shift_en, push, ferr_set, par_smp;
   logic                 fifo_full;

   assign rxd_s = sync2_q;

   // Two-flop synchronizer plus previous synced value for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync1_q    <= serial_rxd;
         sync2_q    <= sync1_q;
         rxd_prev_q <= sync2_q;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: BREAK blocks start detection until the line returns high
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (rxd_prev_q && !rxd_s) state_d = ST_START;
         ST_START:  if (tick) state_d = rxd_s ? ST_IDLE : ST_DATA;
         ST_DATA:   if (tick && bit_cnt_q == BW'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
         end
         ST_PARITY: if (tick) state_d = ST_STOP;
         ST_STOP:   if (tick) state_d = rxd_s ? ST_IDLE : ST_BREAK;
         ST_BREAK:  if (rxd_s) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: sample strobe (half bit in START, full bit elsewhere) and actions
   always_comb begin
      timer_run = 1'b0;
      tick      = 1'b0;
      shift_en  = 1'b0;
      par_smp   = 1'b0;
      push      = 1'b0;
      ferr_set  = 1'b0;
      case (state_q)
         ST_START: begin
            timer_run = 1'b1;
            tick      = (timer_q == TW'(HALF-1));
         end
         ST_DATA: begin
            timer_run = 1'b1;
            tick      = (timer_q == TW'(CLKS_PER_BIT-1));
            shift_en  = tick;
         end
         ST_PARITY: begin
            timer_run = 1'b1;
            tick      = (timer_q == TW'(CLKS_PER_BIT-1));
            par_smp   = tick;
         end
         ST_STOP: begin
            timer_run = 1'b1;
            tick      = (timer_q == TW'(CLKS_PER_BIT-1));
            push      = tick && rxd_s;
            ferr_set  = tick && !rxd_s;
         end
         default: ;
      endcase
   end

   // Datapath: bit timer, bit index, LSB-first shift register, sticky flags
   always_comb begin
      timer_d       = (timer_run && !tick) ? timer_q + TW'(1) : '0;
      bit_cnt_d     = (state_q == ST_IDLE) ? '0 :
                      shift_en ? bit_cnt_q + BW'(1) : bit_cnt_q;
      shift_d       = shift_en ? {rxd_s, shift_q[DATA_BITS-1:1]} : shift_q;
      frame_err_d   = ferr_set || (frame_err_q && !err_clr);
      overrun_err_d = (push && fifo_full && !rd_en) || (overrun_err_q && !err_clr);
   end

   // Receiver datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q       <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         timer_q       <= timer_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = PARITY_ODD[0];

   logic par_bad_q, par_bad_d;
   logic parity_err_q, parity_err_d;

   // Parity check result is held until the stop bit; a bad word is still pushed
   always_comb begin
      par_bad_d    = par_smp ? (rxd_s != (^shift_q ^ PAR_ODD)) : par_bad_q;
      parity_err_d = (push && par_bad_q) || (parity_err_q && !err_clr);
   end

   // Parity state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .wr_data (shift_q),
      .pop     (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (fifo_full),
      .count   (count)
   );

   assign full = fifo_full;

endmodule
